// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus arbiter: FSM encoding,
// default address-map sizing and the slave index map.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_ADDR    = 3'd2,
    ST_CONNECT = 3'd3,
    ST_RELEASE = 3'd4
  } bus_state_e;

  localparam int DEF_SLAVE_BITS = 2;
  localparam int DEF_NUM_SLAVES = 3;

  // Slave indices as decoded from the leading serial address bits.
  localparam logic [1:0] SLV_PERIPH   = 2'b00;
  localparam logic [1:0] SLV_UART_MEM = 2'b01;
  localparam logic [1:0] SLV_REGFILE  = 2'b10;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: first requester after last_owner,
// scanning upward with wrap-around.
module rr_priority_pick #(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [1:0]             last_owner,
  output logic [1:0]             winner,
  output logic                   found
);

  // Padded to the 4-master maximum so a 2-bit index always fits exactly.
  logic [3:0] req_w;
  assign req_w = 4'(req);

  // Scan last_owner+1 .. last_owner+NUM_MASTERS, keep the first hit.
  always_comb begin
    int pos;
    winner = '0;
    found  = 1'b0;
    pos    = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      pos = int'(last_owner) + 1 + k;
      if (pos >= NUM_MASTERS) pos = pos - NUM_MASTERS;
      if (!found && req_w[2'(pos)]) begin
        found  = 1'b1;
        winner = 2'(pos);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Serial system bus arbiter: round-robin ownership, serial slave-address
// capture, one-hot slave select, slave-ready forwarding and timeout abort.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int SLAVE_BITS  = DEF_SLAVE_BITS,
  parameter int TIMEOUT     = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_bus_req,
  input  logic [NUM_MASTERS-1:0] m_valid_s,
  input  logic [NUM_MASTERS-1:0] m_addr,
  input  logic [NUM_SLAVES-1:0]  s_ready,
  output logic [NUM_MASTERS-1:0] m_bus_ready,
  output logic [1:0]             m_sel,
  output logic [NUM_SLAVES-1:0]  s_sel,
  output logic                   busy,
  output logic                   err_decode,
  output logic                   err_timeout
);

  localparam int              SW      = 1 << SLAVE_BITS;
  localparam int              CW      = $clog2(SLAVE_BITS + 1);
  localparam logic [CW-1:0]   CNT_LST = CW'(SLAVE_BITS - 1);
  localparam logic [9:0]      TO_LAST = 10'(TIMEOUT - 1);

  bus_state_e            state;
  logic [1:0]            owner, last_owner;
  logic [SLAVE_BITS-1:0] slave_idx;
  logic [CW-1:0]         bit_cnt;
  logic [9:0]            wait_cnt;

  logic [1:0]            winner;
  logic                  found;

  rr_priority_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req        (m_bus_req),
    .last_owner (last_owner),
    .winner     (winner),
    .found      (found)
  );

  // Owner-indexed views; padded so the index width matches exactly.
  logic [3:0]    req_w, vld_w, addr_w;
  logic [SW-1:0] rdy_w;
  assign req_w  = 4'(m_bus_req);
  assign vld_w  = 4'(m_valid_s);
  assign addr_w = 4'(m_addr);
  assign rdy_w  = SW'(s_ready);

  logic                  own_req, own_vld, own_rdy;
  logic [SLAVE_BITS-1:0] idx_nxt;
  logic                  addr_done, idx_ok, dec_err, to_err;

  assign own_req   = req_w[owner];
  assign own_vld   = vld_w[owner];
  assign own_rdy   = rdy_w[slave_idx];
  // MSB-first shift; the oldest bit falls off the top.
  assign idx_nxt   = SLAVE_BITS'({slave_idx, addr_w[owner]});
  assign addr_done = own_vld && (bit_cnt == CNT_LST);
  assign idx_ok    = 32'(idx_nxt) < NUM_SLAVES;
  assign dec_err   = (state == ST_GRANT || state == ST_ADDR) && addr_done && !idx_ok;
  assign to_err    = (state == ST_CONNECT) && !own_rdy && (wait_cnt == TO_LAST);

  function automatic logic [NUM_MASTERS-1:0] m_onehot(input logic [1:0] i);
    m_onehot = NUM_MASTERS'(4'b0001 << i);
  endfunction

  function automatic logic [NUM_SLAVES-1:0] s_onehot(input logic [SLAVE_BITS-1:0] i);
    s_onehot = NUM_SLAVES'(SW'(1) << i);
  endfunction

  // Bus ownership FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      owner       <= '0;
      last_owner  <= 2'(NUM_MASTERS - 1);
      slave_idx   <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      m_bus_ready <= '0;
      m_sel       <= '0;
      s_sel       <= '0;
      busy        <= 1'b0;
      err_decode  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      // Error pulses are raised even when a request drop wins the exit.
      err_decode  <= dec_err;
      err_timeout <= to_err;
      case (state)
        ST_IDLE: begin
          if (found) begin
            owner       <= winner;
            m_sel       <= winner;
            m_bus_ready <= m_onehot(winner);
            bit_cnt     <= '0;
            busy        <= 1'b1;
            state       <= ST_GRANT;
          end
        end
        ST_GRANT, ST_ADDR: begin
          if (own_vld) begin
            slave_idx <= idx_nxt;
            bit_cnt   <= bit_cnt + 1'b1;
          end
          if (!own_req || dec_err) begin
            m_bus_ready <= '0;
            s_sel       <= '0;
            state       <= ST_RELEASE;
          end else if (own_vld) begin
            m_bus_ready <= '0;
            if (addr_done) begin
              s_sel    <= s_onehot(idx_nxt);
              wait_cnt <= '0;
              state    <= ST_CONNECT;
            end else begin
              state    <= ST_ADDR;
            end
          end
        end
        ST_CONNECT: begin
          if (!own_req || to_err) begin
            m_bus_ready <= '0;
            s_sel       <= '0;
            state       <= ST_RELEASE;
          end else begin
            m_bus_ready <= own_rdy ? m_onehot(owner) : '0;
            wait_cnt    <= own_rdy ? '0 : wait_cnt + 10'd1;
          end
        end
        ST_RELEASE: begin
          m_bus_ready <= '0;
          s_sel       <= '0;
          last_owner  <= owner;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          m_bus_ready <= '0;
          s_sel       <= '0;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: 2 masters, 3 slaves, 2 address bits,
// short timeout so the abort path is reachable quickly.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] m_bus_req, m_valid_s, m_addr;
  logic [2:0] s_ready;
  logic [1:0] m_bus_ready, m_sel;
  logic [2:0] s_sel;
  logic       busy, err_decode, err_timeout;

  int n_chk = 0;
  int n_err = 0;

  bus_arbiter #(
    .NUM_MASTERS(2), .NUM_SLAVES(3), .SLAVE_BITS(2), .TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m_bus_req   (m_bus_req),
    .m_valid_s   (m_valid_s),
    .m_addr      (m_addr),
    .s_ready     (s_ready),
    .m_bus_ready (m_bus_ready),
    .m_sel       (m_sel),
    .s_sel       (s_sel),
    .busy        (busy),
    .err_decode  (err_decode),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},  32'(busy), 32'd0);
    chk({tag, ".rdy"},   32'(m_bus_ready), 32'd0);
    chk({tag, ".ssel"},  32'(s_sel), 32'd0);
  endtask

  int exp_own[4] = '{1, 0, 1, 0};

  initial begin
    reset = 1'b0; m_bus_req = '0; m_valid_s = '0; m_addr = '0; s_ready = '0;
    #2;
    chk_idle("rst");
    chk("rst.msel", 32'(m_sel), 32'd0);
    chk("rst.errd", 32'(err_decode), 32'd0);
    chk("rst.errt", 32'(err_timeout), 32'd0);
    #10 reset = 1'b1;
    step();

    // ---- single request to slave 1 ----
    m_bus_req = 2'b01;
    step();
    chk("t1.grant.rdy", 32'(m_bus_ready), 32'h1);
    chk("t1.grant.msel", 32'(m_sel), 32'd0);
    chk("t1.grant.busy", 32'(busy), 32'd1);
    m_valid_s = 2'b01; m_addr = 2'b00;
    step();
    chk("t1.addr.rdy", 32'(m_bus_ready), 32'h0);
    m_addr = 2'b01;
    step();
    chk("t1.conn.ssel", 32'(s_sel), 32'b010);
    m_valid_s = 2'b00; m_addr = 2'b00; s_ready = 3'b010;
    step();
    chk("t1.conn.rdy", 32'(m_bus_ready), 32'h1);
    m_bus_req = 2'b00; s_ready = 3'b000;
    step();
    chk("t1.rel.busy", 32'(busy), 32'd1);
    chk("t1.rel.rdy", 32'(m_bus_ready), 32'h0);
    chk("t1.rel.ssel", 32'(s_sel), 32'h0);
    step();
    chk_idle("t1.idle");

    // ---- contention: owner drops its request once granted ----
    m_bus_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t2.%0d.msel", k), 32'(m_sel), 32'(exp_own[k]));
      chk($sformatf("t2.%0d.rdy", k), 32'(m_bus_ready), (exp_own[k] == 0) ? 32'h1 : 32'h2);
      m_bus_req = (exp_own[k] == 0) ? 2'b10 : 2'b01;
      step();
      chk($sformatf("t2.%0d.gap1", k), 32'(m_bus_ready), 32'h0);
      m_bus_req = 2'b11;
      step();
      chk($sformatf("t2.%0d.gap2", k), 32'(m_bus_ready), 32'h0);
      chk($sformatf("t2.%0d.busy", k), 32'(busy), 32'd0);
    end

    // ---- decode error: master 1 shifts 1,1 (index 3 >= 3 slaves) ----
    step();
    chk("t3.grant.msel", 32'(m_sel), 32'd1);
    m_valid_s = 2'b10; m_addr = 2'b10;
    step();
    chk("t3.addr.errd", 32'(err_decode), 32'd0);
    step();
    chk("t3.errd", 32'(err_decode), 32'd1);
    chk("t3.ssel", 32'(s_sel), 32'h0);
    chk("t3.rdy", 32'(m_bus_ready), 32'h0);
    m_valid_s = 2'b00; m_addr = 2'b00;
    step();
    chk("t3.errd.pulse", 32'(err_decode), 32'd0);
    chk("t3.idle.busy", 32'(busy), 32'd0);
    step();
    chk("t3.next.msel", 32'(m_sel), 32'd0);
    chk("t3.next.rdy", 32'(m_bus_ready), 32'h1);
    m_bus_req = 2'b00;
    step();
    step();
    chk_idle("t3.idle2");

    // ---- stall in ADDR, then slave 2 with timeout ----
    m_bus_req = 2'b01;
    step();
    chk("t4.grant.msel", 32'(m_sel), 32'd0);
    m_valid_s = 2'b01; m_addr = 2'b01;
    step();
    m_valid_s = 2'b00; m_addr = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t4.stall%0d.ssel", i), 32'(s_sel), 32'h0);
      chk($sformatf("t4.stall%0d.busy", i), 32'(busy), 32'd1);
    end
    m_valid_s = 2'b01; m_addr = 2'b00;
    step();
    chk("t4.conn.ssel", 32'(s_sel), 32'b100);
    chk("t4.conn.errd", 32'(err_decode), 32'd0);
    m_valid_s = 2'b00;
    for (int i = 0; i < 5; i++) step();
    chk("t5.wait.errt", 32'(err_timeout), 32'd0);
    s_ready = 3'b100;
    step();
    chk("t5.rdy.fwd", 32'(m_bus_ready), 32'h1);
    s_ready = 3'b000;
    for (int i = 0; i < 7; i++) step();
    chk("t5.pre.errt", 32'(err_timeout), 32'd0);
    chk("t5.pre.rdy", 32'(m_bus_ready), 32'h0);
    chk("t5.pre.ssel", 32'(s_sel), 32'b100);
    step();
    chk("t5.errt", 32'(err_timeout), 32'd1);
    chk("t5.rdy", 32'(m_bus_ready), 32'h0);
    chk("t5.ssel", 32'(s_sel), 32'h0);
    step();
    chk("t5.errt.pulse", 32'(err_timeout), 32'd0);
    chk_idle("t5.idle");

    // ---- reset mid-CONNECT: master 0 on slave 0, last_owner is 0 ----
    step();
    chk("t6.grant.msel", 32'(m_sel), 32'd0);
    m_valid_s = 2'b01; m_addr = 2'b00;
    step();
    step();
    chk("t6.conn.ssel", 32'(s_sel), 32'b001);
    m_valid_s = 2'b00; s_ready = 3'b001;
    step();
    chk("t6.conn.rdy", 32'(m_bus_ready), 32'h1);
    #3 reset = 1'b0;
    #1;
    chk_idle("t6.rst");
    chk("t6.rst.msel", 32'(m_sel), 32'd0);
    m_bus_req = 2'b11; s_ready = 3'b000;
    #2 reset = 1'b1;
    step();
    chk("t6.prio.msel", 32'(m_sel), 32'd0);
    chk("t6.prio.rdy", 32'(m_bus_ready), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central controller for the shared serial system bus.
- Arbitrates bus ownership between NUM_MASTERS serial masters (UART bridge, internal masters) using round-robin priority.
- Captures the slave-select MSBs of the granted master's serial address and drives one-hot slave selects.
- Drives the per-master bus_ready line (grant, then forwarded slave ready) and aborts transactions whose slave never becomes ready.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- NUM_SLAVES, 3, number of slaves (1..4).
- SLAVE_BITS, 2, leading serial address bits that select the slave (MSB first).
- TIMEOUT, 1023, max cycles in CONNECT with the selected slave not ready before abort (10-bit counter).

Ports:
- clk  in  1  bus clock.
- reset  in  1  asynchronous, active-low reset.
- m_bus_req  in  NUM_MASTERS  per-master bus request, level.
- m_valid_s  in  NUM_MASTERS  per-master serial-frame valid; high while address/data bits are shifted.
- m_addr  in  NUM_MASTERS  per-master serial address line.
- m_bus_ready  out  NUM_MASTERS  per-master grant / slave-ready indication.
- m_sel  out  2  index of the current owner (for bus mux).
- s_sel  out  NUM_SLAVES  one-hot slave select.
- busy  out  1  bus owned (any state except IDLE).
- err_decode  out  1  one-cycle pulse: captured slave index >= NUM_SLAVES.
- err_timeout  out  1  one-cycle pulse: CONNECT timed out.

Behaviour:
- Reset (reset low, asynchronous):
  - Outputs: all outputs 0.
  - FSM goes to IDLE.
  - Round-robin pointer last_owner = NUM_MASTERS-1, so master 0 has first priority.
  - Counters are cleared.
- All state updates occur on posedge clk. The outputs are registered.
- IDLE:
  - If any m_bus_req bit is high, choose the first requester scanning last_owner+1, last_owner+2, … with wrap-around.
  - Register owner and m_sel, then go to GRANT.
  - Latency: request to m_bus_ready[owner]=1 is 1 cycle after the sampling edge.
- GRANT:
  - m_bus_ready[owner]=1.
  - bit_cnt=0.
  - Go to ADDR on the first cycle m_valid_s[owner]=1; that cycle's m_addr[owner] is captured as bit SLAVE_BITS-1.
- ADDR:
  - Each cycle with m_valid_s[owner]=1, shift m_addr[owner] into slave_idx and increment bit_cnt.
  - Cycles with m_valid_s low are ignored (stall).
  - m_bus_ready[owner]=0 while capturing.
  - After SLAVE_BITS bits:
    - If slave_idx < NUM_SLAVES, go to CONNECT.
    - Else pulse err_decode and go to RELEASE.
- CONNECT:
  - s_sel = onehot(slave_idx).
  - m_bus_ready[owner] = s_ready of the selected slave, taken from input s_ready[NUM_SLAVES] (in, NUM_SLAVES bits; one ready per slave, listed here with the ports).
  - wait_cnt increments on each cycle the selected slave is not ready and clears when it is ready.
  - If wait_cnt reaches TIMEOUT, pulse err_timeout and go to RELEASE.
- RELEASE:
  - Entered from any non-IDLE state when m_bus_req[owner] falls (highest priority exit).
  - Also entered on a decode error or a timeout.
  - For one cycle: all m_bus_ready=0, s_sel=0, last_owner=owner.
  - Then go to IDLE. The minimum gap between owners is 2 cycles, so the bus is never granted back-to-back without a gap.
- Non-owner masters always see m_bus_ready=0. Their requests stay pending (level) and no request is lost.
- Simultaneous request drop and error on the same cycle: go to RELEASE, and the error pulse is still emitted.
- Requests that change while in RELEASE or IDLE are evaluated only at the IDLE decision cycle.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. The round-robin pointer is reset.
- NUM_MASTERS=1 degenerates to grant/release with no arbitration.

Decomposition:
- Shared package bus_pkg:
  - FSM state encoding (IDLE, GRANT, ADDR, CONNECT, RELEASE, 3 bits).
  - Default SLAVE_BITS, NUM_SLAVES.
  - Slave index constants matching the address map (e.g. 2'b01 = UART-target memory).
- One sub-module: rr_priority_pick.
  - Combinational round-robin selector.
  - Inputs: request vector, last_owner.
  - Outputs: winner index, found flag.

Test Plan:
- Single request: m_bus_req=01 → m_bus_ready[0]=1 one cycle later; serial bits 0,1 under m_valid_s → s_sel=010; s_ready[1]=1 → m_bus_ready[0]=1; drop req → 1-cycle RELEASE, then IDLE.
- Contention: both masters requesting continuously → grants alternate 0,1,0,1 over 4 transactions with a ≥2-cycle gap between owners.
- Decode error: NUM_SLAVES=3, master shifts 1,1 → err_decode pulses once, s_sel stays 000, bus released, other pending master granted next.
- Timeout: TIMEOUT=8, s_ready held 0 in CONNECT → err_timeout pulses on the 8th not-ready cycle, m_bus_ready=0, FSM back in IDLE after RELEASE.
- Stall in ADDR: m_valid_s low for 3 cycles between the two address bits → correct slave_idx captured, no error.
- Reset mid-CONNECT: drive reset low asynchronously (between edges) → all outputs 0 immediately; after release, master 0 has first priority.
